// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO consumer-side logic.
package fifo_pkg;

  // Skid buffer occupancy; the encoding 2'd3 is unused and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: head register drives the output, skid register
// absorbs one extra word so the upstream pop never waits on downstream ready.
module skid_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  can_push
);

  occ_t                  occ_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] skid_r;
  logic                  xfer_s;

  // Outputs decode straight from registered state; the illegal code reads as EMPTY.
  assign valid    = (occ_r == ONE) || (occ_r == TWO);
  assign data     = head_r;
  assign can_push = (occ_r != TWO);
  assign xfer_s   = valid & pop;

  // Occupancy FSM with head/skid data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occ_r  <= EMPTY;
      head_r <= {DATA_WIDTH{1'b0}};
      skid_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (occ_r)
        EMPTY: begin
          if (push) begin
            head_r <= push_data;
            occ_r  <= ONE;
          end else begin
            occ_r  <= EMPTY;
          end
        end
        ONE: begin
          if (push && xfer_s) begin
            head_r <= push_data;
            occ_r  <= ONE;
          end else if (push) begin
            skid_r <= push_data;
            occ_r  <= TWO;
          end else if (xfer_s) begin
            occ_r  <= EMPTY;
          end else begin
            occ_r  <= ONE;
          end
        end
        TWO: begin
          // can_push is low here, so only the drain path exists.
          if (xfer_s) begin
            head_r <= skid_r;
            occ_r  <= ONE;
          end else begin
            occ_r  <= TWO;
          end
        end
        default: begin
          // Illegal code behaves as EMPTY and is cleaned up at this edge.
          if (push) begin
            head_r <= push_data;
            occ_r  <= ONE;
          end else begin
            occ_r  <= EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Consumer-side FIFO engine: pops show-ahead FIFO words into a skid buffer
// and re-presents them as a valid/ready stream, counting delivered words.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_read,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COUNT_WIDTH-1:0] word_count
);

  logic can_push_s;
  logic xfer_s;

  // Pop only from registered occupancy, never from out_ready; reset kills it.
  assign fifo_read = reset & enable & ~fifo_empty & can_push_s;
  assign xfer_s    = out_valid & out_ready;

  skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_read),
    .push_data (fifo_data),
    .pop       (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .can_push  (can_push_s)
  );

  // Count completed output handshakes, wrapping naturally at all-ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_count <= {COUNT_WIDTH{1'b0}};
    end else if (xfer_s) begin
      word_count <= word_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      word_count <= word_count;
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader against a queue-based reference model.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_read;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] word_count;

  logic        fifo_read4;
  logic        out_valid4;
  logic [7:0]  out_data4;
  logic [3:0]  word_count4;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .word_count(word_count)
  );

  fifo_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read(fifo_read4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .word_count(word_count4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents, buffered words, delivered count.
  logic [7:0] fifo_q[$];
  logic [7:0] buf_q[$];
  int         cnt   = 0;
  bit         fresh = 1'b1;
  bit         rst   = 1'b0;
  bit         en    = 1'b1;
  bit         rdy   = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step();
    bit exp_read;
    bit exp_valid;
    @(negedge clk);
    reset      = rst;
    enable     = en;
    out_ready  = rdy;
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
    #1;
    exp_read  = rst && en && (fifo_q.size() != 0) && (buf_q.size() < 2);
    exp_valid = (buf_q.size() != 0);
    check("fifo_read",  32'(fifo_read),  32'(exp_read));
    check("fifo_read4", 32'(fifo_read4), 32'(exp_read));
    check("out_valid",  32'(out_valid),  32'(exp_valid));
    check("out_valid4", 32'(out_valid4), 32'(exp_valid));
    if (exp_valid) begin
      check("out_data", 32'(out_data), 32'(buf_q[0]));
    end else if (fresh) begin
      check("out_data_rst", 32'(out_data), 32'd0);
    end
    check("word_count",  32'(word_count),  32'(cnt & 32'hFFFF));
    check("word_count4", 32'(word_count4), 32'(cnt & 32'hF));
    if (!rst) begin
      buf_q.delete();
      cnt   = 0;
      fresh = 1'b1;
    end else begin
      if (exp_valid && rdy) begin
        void'(buf_q.pop_front());
        cnt++;
      end
      if (exp_read) begin
        buf_q.push_back(fifo_q.pop_front());
        fresh = 1'b0;
      end
    end
  endtask

  initial begin
    int  start_cnt;
    bit  done;
    reset      = 1'b0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    @(posedge clk);

    // Reset held with a word waiting, then release.
    fifo_q.push_back(8'hAA);
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rel_read_seen", 32'(fifo_read), 32'd1);

    // Streaming 01..10 at full rate.
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    repeat (20) step();
    check("stream_count", 32'(word_count), 32'd17);

    // Back-pressure: two pops then hold.
    fifo_q.push_back(8'h21); fifo_q.push_back(8'h22); fifo_q.push_back(8'h23);
    rdy = 1'b0;
    repeat (5) step();
    check("bp_head", 32'(out_data), 32'h21);
    check("bp_left", 32'(fifo_q.size()), 32'd1);
    rdy = 1'b1;
    repeat (5) step();

    // Random stall over 64 random words.
    start_cnt = cnt;
    for (int i = 0; i < 64; i++) fifo_q.push_back(8'($urandom));
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      rdy = 1'($urandom_range(0, 1));
      step();
      done = (fifo_q.size() == 0) && (buf_q.size() == 0);
    end
    check("rand_drained", 32'(done), 32'd1);
    rdy = 1'b1;
    step();
    check("rand_count", 32'(word_count), 32'((start_cnt + 64) & 32'hFFFF));

    // Enable gating: fill, stop popping, drain, resume.
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'h40 + 8'(i));
    rdy = 1'b0;
    repeat (2) step();
    en  = 1'b0;
    rdy = 1'b1;
    repeat (4) step();
    check("gate_idle", 32'(out_valid), 32'd0);
    check("gate_left", 32'(fifo_q.size()), 32'd2);
    en = 1'b1;
    repeat (6) step();

    // Counter wrap on the 4-bit instance.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom));
    repeat (19) step();
    check("wrap_cnt4", 32'(word_count4), 32'd1);

    // Reset while two words are buffered.
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'h60 + 8'(i));
    rdy = 1'b0;
    repeat (3) step();
    check("pre_rst_full", 32'(buf_q.size()), 32'd2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_count", 32'(word_count), 32'd0);
    rdy = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
